// File: rtl/soc_pio_pkg.sv
// Register map and bus helpers for the soc_system edge-capture PIO.
package soc_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;

    localparam int DATA_W = 32;

    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/soc_system_pio_edge_irq_if.sv
// Avalon-MM slave port of the edge-capture PIO, grouped for module connections.
interface soc_system_pio_edge_irq_if;
    import soc_pio_pkg::*;

    // A write happens on the clk edge where chipselect is high and write_n low;
    // readdata follows address one clock later regardless of chipselect.
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus per-bit rising/falling edge detection.
module pio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_vec
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    // prev resets to 0 so an input held high through reset looks like a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                chain[k] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
            prev <= sync;
        end
    end

    assign sync     = chain[SYNC_STAGES-1];
    assign edge_vec = (rise_en & sync & ~prev) | (fall_en & ~sync & prev);

endmodule

// File: rtl/soc_system_pio_edge_irq.sv
// Parametrised input PIO: CSRs, sticky edge capture with W1C, read mux and masked irq.
module soc_system_pio_edge_irq
    import soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RISE_RESET  = '1,
    parameter logic [WIDTH-1:0] FALL_RESET  = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    soc_system_pio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);

    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  sync;
    logic [WIDTH-1:0]  edge_vec;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  w1c;
    logic [WIDTH-1:0]  edge_cap_next;
    logic [DATA_W-1:0] readdata_next;
    logic              wr;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .sync     (sync),
        .edge_vec (edge_vec)
    );

    assign wr    = is_write(bus.chipselect, bus.write_n);
    assign wdata = bus.writedata[WIDTH-1:0];
    assign w1c   = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;

    if (WIDTH < DATA_W) begin : g_unused_wdata
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^bus.writedata[DATA_W-1:WIDTH];
    end

    // A new edge overrides a same-cycle clear so no event is ever dropped.
    assign edge_cap_next = edge_vec | (edge_cap & ~w1c);

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA:     readdata_next[WIDTH-1:0] = sync;
            ADDR_RISE_EN:  readdata_next[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK: readdata_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata_next[WIDTH-1:0] = edge_cap;
            ADDR_FALL_EN:  readdata_next[WIDTH-1:0] = fall_en;
            default:       readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= RISE_RESET;
            fall_en  <= FALL_RESET;
            irq_mask <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap     <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            edge_cap     <= edge_cap_next;
            irq          <= |(edge_cap & irq_mask);
            bus.readdata <= readdata_next;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// Directed bench for the edge-capture PIO with an expected-value queue for bus reads.
module tb_soc_system_pio_edge_irq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    soc_system_pio_edge_irq_if bus();

    soc_system_pio_edge_irq #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.address = a;
        exp_q.push_back(exp);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            check(tag, bus.readdata, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] reset_vals [8];
        reset_vals = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset values
        tick(3);
        check("irq_in_reset", {31'b0, irq}, 32'h0);
        check("rd_in_reset", bus.readdata, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), reset_vals[i], $sformatf("reset_addr%0d", i));
        end
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        // Rising edge on bit0, irq and W1C timing
        bus_write(3'd2, 32'h01);
        @(negedge clk);
        bus.address = 3'd3;
        in_port = 8'h01;
        tick(1);
        check("t2_irq_T", {31'b0, irq}, 32'h0);
        tick(2);
        check("t2_cap_T2", bus.readdata, 32'h0);
        check("t2_irq_T2", {31'b0, irq}, 32'h0);
        tick(1);
        check("t2_cap_T3", bus.readdata, 32'h01);
        check("t2_irq_T3", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h01);
        check("t2_irq_still_high", {31'b0, irq}, 32'h1);
        tick(1);
        check("t2_irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(3'd3, 32'h0, "t2_cap_cleared");
        bus_read(3'd0, 32'h01, "t2_data");

        // Falling-only on bit7
        bus_write(3'd1, 32'h7F);
        bus_write(3'd4, 32'h80);
        in_port = 8'h81;
        tick(5);
        bus_read(3'd3, 32'h0, "t3_rise_bit7_ignored");
        bus_read(3'd0, 32'h81, "t3_data");
        in_port = 8'h01;
        tick(5);
        bus_read(3'd3, 32'h80, "t3_fall_bit7");
        check("t3_irq_masked", {31'b0, irq}, 32'h0);
        bus_write(3'd3, 32'h80);
        bus_read(3'd3, 32'h0, "t3_cleared");
        in_port = 8'h81;
        tick(5);
        bus_read(3'd3, 32'h0, "t3_rise_again_ignored");
        in_port = 8'h01;
        tick(5);
        bus_write(3'd3, 32'hFF);

        // Both enables on bit3, four toggles
        bus_write(3'd4, 32'h88);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_port = in_port ^ 8'h08;
        end
        tick(6);
        bus_read(3'd3, 32'h08, "t4_sticky_bit3");
        bus_write(3'd3, 32'h08);
        bus_read(3'd3, 32'h0, "t4_cleared");

        // Edge and W1C on the same clock
        in_port = 8'h21;
        tick(5);
        bus_read(3'd3, 32'h20, "t5_bit5");
        @(negedge clk);
        in_port = 8'h25;
        tick(1);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, 32'h24, "t5_set_wins");
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, 32'h20, "t5_clear_bit2_only");

        // Unmapped addresses and register read-back
        bus_write(3'd5, 32'hFF);
        bus_write(3'd7, 32'hFF);
        bus_read(3'd5, 32'h0, "unmapped5");
        bus_read(3'd7, 32'h0, "unmapped7");
        bus_read(3'd1, 32'h7F, "rise_en_rb");
        bus_read(3'd4, 32'h88, "fall_en_rb");

        // Asynchronous reset while irq is high
        bus_write(3'd2, 32'h20);
        tick(2);
        check("t6_irq_before_reset", {31'b0, irq}, 32'h1);
        @(negedge clk);
        bus.address = 3'd3;
        in_port = 8'h01;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_irq_async", {31'b0, irq}, 32'h0);
        check("t6_rd_async", bus.readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        bus_read(3'd3, 32'h01, "t6_held_high_captured");
        bus_read(3'd2, 32'h0, "t6_mask_reset");
        bus_read(3'd1, 32'hFF, "t6_rise_reset");
        check("t6_irq_after", {31'b0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
